// File: rtl/tia_video_capture_pkg.sv
// Shared constants for the TIA video capture slice: sync thresholds, FIFO geometry,
// FSM encodings and field widths. TIA_VIDEO_CAPTURE_COORD_EN widens FIFO entries with coordinates.
package tia_video_capture_pkg;

  localparam logic [7:0] VSYNC_MIN  = 8'd100;
  localparam int         FIFO_DEPTH = 4;
  localparam int         PIX_W      = 7;
  localparam int         COL_W      = 8;
  localparam int         LINE_W     = 9;

`ifdef TIA_VIDEO_CAPTURE_COORD_EN
  localparam int ENTRY_W = PIX_W + COL_W + LINE_W;
`else
  localparam int ENTRY_W = PIX_W;
`endif

  localparam logic [1:0] ST_WAIT_VSYNC = 2'd0;
  localparam logic [1:0] ST_IN_VSYNC   = 2'd1;
  localparam logic [1:0] ST_WAIT_LINE  = 2'd2;
  localparam logic [1:0] ST_ACTIVE     = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/tia_video_capture_fifo.sv
// Small first-word-fall-through FIFO for captured pixels; push and pop may coincide
// even when full. Read data is forced to zero while empty.
module tia_video_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             drop_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s, do_pop, do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign valid_o = (count_q != {CNT_W{1'b0}});
  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_s | do_pop);
  assign drop_o  = push_i & full_s & ~do_pop;
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible while occupied
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/tia_video_capture.sv
// TIA video capture: input register, sync decode, frame/line FSM and coordinate counters
// feeding a 4-entry pixel FIFO. Define TIA_VIDEO_CAPTURE_COORD_EN to carry col/line per pixel.
module tia_video_capture
  import tia_video_capture_pkg::*;
(
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       syn,
  input  logic       blk_bar,
  input  logic [2:0] l,
  input  logic [3:0] c,
  input  logic       pix_ready,
  output logic       pix_valid,
  output logic [6:0] pix_data,
  output logic [7:0] pix_col,
  output logic [8:0] pix_line,
  output logic       line_start,
  output logic       frame_start,
  output logic       overflow
);

  logic             syn_q, blk_q;
  logic [2:0]       l_q;
  logic [3:0]       c_q;
  logic [7:0]       syn_len_q, syn_len_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       col_q, col_d, push_col;
  logic [8:0]       line_q, line_d, push_line;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             overflow_q, overflow_d;
  logic             vsync_hit, syn_fall, hsync_fall, line_ev, push, fifo_drop;
  logic [ENTRY_W-1:0] wdata, rdata;

  assign syn_len_d  = syn_q ? sat_inc8(syn_len_q) : 8'd0;
  assign vsync_hit  = syn_q & (syn_len_d == VSYNC_MIN);
  assign syn_fall   = ~syn_q & (syn_len_q != 8'd0);
  assign hsync_fall = syn_fall & (syn_len_q < VSYNC_MIN);
  assign line_ev    = hsync_fall & ((state_q == ST_WAIT_LINE) | (state_q == ST_ACTIVE));
  // The pixel coinciding with the hsync falling edge is the first pixel of the new line
  assign push       = blk_q & ~syn_q & ((state_q == ST_ACTIVE) | line_ev);
  assign push_col   = line_ev ? 8'd0 : col_q;
  assign push_line  = line_ev ? sat_inc9(line_q) : line_q;

  // FSM, counters and pulse next-state
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    line_d        = line_q;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    overflow_d    = overflow_q | fifo_drop;
    case (state_q)
      ST_WAIT_VSYNC: begin
        if (vsync_hit) state_d = ST_IN_VSYNC;
        else           state_d = ST_WAIT_VSYNC;
      end
      ST_IN_VSYNC: begin
        if (syn_fall) begin
          state_d       = ST_WAIT_LINE;
          frame_start_d = 1'b1;
          line_d        = 9'd0;
          col_d         = 8'd0;
          overflow_d    = 1'b0;
        end else begin
          state_d = ST_IN_VSYNC;
        end
      end
      ST_WAIT_LINE, ST_ACTIVE: begin
        if (vsync_hit)       state_d = ST_IN_VSYNC;
        else if (hsync_fall) state_d = ST_ACTIVE;
        else                 state_d = state_q;
      end
      default: state_d = ST_WAIT_VSYNC;
    endcase
    if (line_ev) begin
      line_d       = push_line;
      line_start_d = 1'b1;
    end else begin
      line_start_d = 1'b0;
    end
    if (push)         col_d = sat_inc8(push_col);
    else if (line_ev) col_d = 8'd0;
    else              col_d = col_d;
  end

  // Input stage and control state
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      syn_q         <= 1'b0;
      blk_q         <= 1'b0;
      l_q           <= 3'd0;
      c_q           <= 4'd0;
      syn_len_q     <= 8'd0;
      state_q       <= ST_WAIT_VSYNC;
      col_q         <= 8'd0;
      line_q        <= 9'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      syn_q         <= syn;
      blk_q         <= blk_bar;
      l_q           <= l;
      c_q           <= c;
      syn_len_q     <= syn_len_d;
      state_q       <= state_d;
      col_q         <= col_d;
      line_q        <= line_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef TIA_VIDEO_CAPTURE_COORD_EN
  assign wdata    = {c_q, l_q, push_col, push_line};
  assign pix_data = rdata[ENTRY_W-1 -: PIX_W];
  assign pix_col  = rdata[LINE_W +: COL_W];
  assign pix_line = rdata[LINE_W-1:0];
`else
  assign wdata    = {c_q, l_q};
  assign pix_data = rdata;
  assign pix_col  = 8'd0;
  assign pix_line = 9'd0;
`endif

  tia_video_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_bar (reset_bar),
    .push_i    (push),
    .wdata_i   (wdata),
    .pop_i     (pix_ready),
    .rdata_o   (rdata),
    .valid_o   (pix_valid),
    .drop_o    (fifo_drop)
  );

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign overflow    = overflow_q;

endmodule
